// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants for the iterative shift sequencer.
package shift_seq_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned AMT_W_DEF = 5;

  // FSM encodings; 2'd3 is unreachable and recovers to IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter: logical left (zero fill) or arithmetic right (sign fill).
module shift_step #(
  parameter int unsigned WIDTH = shift_seq_ctrl_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] I,
  input  logic             SHIFT,
  input  logic             RIGHT,
  output logic [WIDTH-1:0] O
);

  // Pass-through unless a step is requested
  always_comb begin
    O = I;
    if (SHIFT) begin
      if (RIGHT == shift_seq_ctrl_pkg::DIR_RIGHT) begin
        O = {I[WIDTH-1], I[WIDTH-1:1]};
      end else begin
        O = {I[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one bit position per clock, DONE pulse on completion.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OPERAND,
  input  logic [AMT_W-1:0] AMOUNT,
  input  logic             RIGHT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  logic [1:0]       state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q,   dir_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] step_o;

  // One shift step per SHIFT cycle; otherwise the accumulator passes through
  shift_step #(.WIDTH(WIDTH)) u_step (
    .I     (acc_q),
    .SHIFT (state_q == SHIFT),
    .RIGHT (dir_q),
    .O     (step_o)
  );

  // Next-state, counter and accumulator update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    acc_d   = step_o;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          acc_d   = OPERAND;
          count_d = AMOUNT;
          dir_d   = RIGHT;
          state_d = (AMOUNT == '0) ? FIN : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = FIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= DIR_LEFT;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == FIN);
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = acc_q;

endmodule
